mm_uart_sequencer: RTL and testbench

Command sequencer between the UART byte link and the matrix-multiply engine. It parses a host packet: opcode, four dimension bytes, then A and B operands as big-endian 32-bit floats. It loads the operands into the engine's A/B buffers, starts the engine and waits for completion. It then streams the result matrix back over UART TX, MSB byte first. It sits in the accelerator top between the `uart` instance (through the rx-done one-cycle detector) and the engine/buffers.

---
 rtl/mm_uart_pkg.sv | 35 +++
 rtl/mm_uart_sequencer_packer.sv | 31 +++
 rtl/mm_uart_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mm_uart_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_uart_pkg.sv
// Shared constants, state encoding and byte helpers for the UART-to-matmul sequencer.
package mm_uart_pkg;

  localparam int DIM_W_DEF  = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] OP_MATRIX_MULT = 8'h4D;
  localparam logic [7:0] ERR_BYTE       = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT_MM,
    S_RD_RES,
    S_RD_LAT,
    S_TX_BYTE,
    S_ERR_TX
  } seq_state_t;

  // Byte idx of a big-endian word, idx 0 = MSB.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mm_uart_sequencer_packer.sv
// Big-endian 4-byte word assembler; word/word_vld are valid in the cycle of the 4th byte.
module be_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_vld
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  assign word_vld = byte_vld && (cnt == 2'd3);
  assign word     = {acc, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (byte_vld) begin
      cnt <= cnt + 2'd1;
      acc <= {acc[15:0], byte_in};
    end
  end

endmodule

// File: rtl/mm_uart_sequencer.sv
// Host packet parser: loads A/B buffers from UART, runs the matmul engine and
// streams the result matrix back over UART TX, MSB byte first.
module mm_uart_sequencer
  import mm_uart_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              a_we,
  output logic              b_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              mm_start,
  output logic [DIM_W-1:0]  mm_a_h,
  output logic [DIM_W-1:0]  mm_a_w,
  output logic [DIM_W-1:0]  mm_b_w,
  input  logic              mm_done,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [31:0]       res_data,
  output logic              busy,
  output logic              err
);

  // Products need 2*DIM_W bits but must also be able to hold 2^ADDR_W itself.
  localparam int PW = (2 * DIM_W > ADDR_W) ? 2 * DIM_W : ADDR_W + 1;
  localparam logic [PW-1:0] MAX_EL = PW'(1) << ADDR_W;

  seq_state_t       state;
  logic [1:0]       byte_cnt;
  logic [PW-1:0]    elem_cnt;
  logic [PW-1:0]    n_a, n_b, n_r;
  logic [DIM_W-1:0] hdr_b_h;
  logic [31:0]      res_word;

  logic             loading;
  logic             pk_vld;
  logic [31:0]      pk_word;
  logic [DIM_W-1:0] rx_dim;
  logic [PW-1:0]    p_a, p_b, p_r;
  logic             hdr_ok;

  assign loading = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign busy    = (state != S_IDLE);

  be_word_packer u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!loading),
    .byte_vld (rx_done && loading),
    .byte_in  (rx_data),
    .word     (pk_word),
    .word_vld (pk_vld)
  );

  // Header check runs on the 4th header byte, so b_w comes straight off rx_data.
  assign rx_dim = DIM_W'(rx_data);
  assign p_a    = PW'(mm_a_h) * PW'(mm_a_w);
  assign p_b    = PW'(hdr_b_h) * PW'(rx_dim);
  assign p_r    = PW'(mm_a_h) * PW'(rx_dim);
  assign hdr_ok = (mm_a_h != '0) && (mm_a_w != '0) && (hdr_b_h != '0) && (rx_dim != '0) &&
                  (mm_a_w == hdr_b_h) && (p_a <= MAX_EL) && (p_b <= MAX_EL) && (p_r <= MAX_EL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      elem_cnt <= '0;
      n_a      <= '0;
      n_b      <= '0;
      n_r      <= '0;
      hdr_b_h  <= '0;
      res_word <= '0;
      tx_send  <= 1'b0;
      tx_data  <= '0;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mm_start <= 1'b0;
      mm_a_h   <= '0;
      mm_a_w   <= '0;
      mm_b_w   <= '0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      err      <= 1'b0;
    end else begin
      tx_send  <= 1'b0;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      mm_start <= 1'b0;
      res_rd   <= 1'b0;
      case (state)
        S_IDLE: if (rx_done) begin
          if (rx_data == OP_MATRIX_MULT) begin
            err      <= 1'b0;
            byte_cnt <= '0;
            state    <= S_HDR;
          end else begin
            err     <= 1'b1;
            tx_data <= ERR_BYTE;
            tx_send <= 1'b1;
            state   <= S_ERR_TX;
          end
        end
        S_HDR: if (rx_done) begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: mm_a_h  <= rx_dim;
            2'd1: mm_a_w  <= rx_dim;
            2'd2: hdr_b_h <= rx_dim;
            default: begin
              mm_b_w   <= rx_dim;
              elem_cnt <= '0;
              n_a      <= p_a;
              n_b      <= p_b;
              n_r      <= p_r;
              if (hdr_ok) begin
                state <= S_LOAD_A;
              end else begin
                err     <= 1'b1;
                tx_data <= ERR_BYTE;
                tx_send <= 1'b1;
                state   <= S_ERR_TX;
              end
            end
          endcase
        end
        S_LOAD_A: if (pk_vld) begin
          a_we    <= 1'b1;
          wr_addr <= ADDR_W'(elem_cnt);
          wr_data <= pk_word;
          if (elem_cnt == n_a - 1'b1) begin
            elem_cnt <= '0;
            state    <= S_LOAD_B;
          end else begin
            elem_cnt <= elem_cnt + 1'b1;
          end
        end
        S_LOAD_B: if (pk_vld) begin
          b_we    <= 1'b1;
          wr_addr <= ADDR_W'(elem_cnt);
          wr_data <= pk_word;
          if (elem_cnt == n_b - 1'b1) begin
            elem_cnt <= '0;
            state    <= S_START;
          end else begin
            elem_cnt <= elem_cnt + 1'b1;
          end
        end
        S_START: begin
          mm_start <= 1'b1;
          state    <= S_WAIT_MM;
        end
        S_WAIT_MM: if (mm_done) begin
          res_rd   <= 1'b1;
          res_addr <= '0;
          elem_cnt <= '0;
          state    <= S_RD_RES;
        end
        // Result RAM has one cycle of read latency.
        S_RD_RES: state <= S_RD_LAT;
        S_RD_LAT: begin
          res_word <= res_data;
          tx_data  <= res_data[31:24];
          tx_send  <= 1'b1;
          byte_cnt <= '0;
          state    <= S_TX_BYTE;
        end
        S_TX_BYTE: if (tx_done) begin
          if (byte_cnt == 2'd3) begin
            if (elem_cnt == n_r - 1'b1) begin
              state <= S_IDLE;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
              res_rd   <= 1'b1;
              res_addr <= ADDR_W'(elem_cnt + 1'b1);
              state    <= S_RD_RES;
            end
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
            tx_data  <= be_byte(res_word, byte_cnt + 2'd1);
            tx_send  <= 1'b1;
          end
        end
        S_ERR_TX: if (tx_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_uart_sequencer.sv
// Directed bench for mm_uart_sequencer with a behavioural packet/matmul model,
// bench-side engine and UART TX responders.
module tb_mm_uart_sequencer;
  import mm_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        a_we, b_we;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mm_start;
  logic [7:0]  mm_a_h, mm_a_w, mm_b_w;
  logic        mm_done;
  logic        res_rd;
  logic [7:0]  res_addr;
  logic [31:0] res_data;
  logic        busy, err;

  always #5 clk = ~clk;

  mm_uart_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done),
    .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .mm_start(mm_start), .mm_a_h(mm_a_h), .mm_a_w(mm_a_w), .mm_b_w(mm_b_w),
    .mm_done(mm_done), .res_rd(res_rd), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .err(err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_start = 0;
  int          n_start = 0;
  int          tx_delay = 2;
  logic [23:0] exp_dims;
  logic [39:0] exp_a[$], exp_b[$];
  logic [7:0]  exp_tx[$], tx_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] res_mem [256];
  int          A_v [256];
  int          B_v [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen, required none", name);
  endtask

  // Positive integer to IEEE-754 single (exact for values below 2^24).
  function automatic logic [31:0] f32(input int unsigned v);
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 32; i++) if (v[i]) e = i;
    m = v << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Previous-cycle view of strobes, for latency checks.
  logic rx_q, mm_q, txd_q, bwe_q;
  always @(posedge clk) begin
    rx_q  <= rx_done;
    mm_q  <= mm_done;
    txd_q <= tx_done;
    bwe_q <= b_we;
  end

  // Compare process.
  initial begin
    int rd_idx = 0;
    forever begin
      @(negedge clk);
      if (a_we) begin
        wr_log.push_back(wr_data);
        check("a_we_lat", 64'(rx_q), 64'd1);
        if (exp_a.size() == 0) flag("a_we_extra");
        else check("a_wr", 64'({wr_addr, wr_data}), 64'(exp_a.pop_front()));
      end
      if (b_we) begin
        check("b_we_lat", 64'(rx_q), 64'd1);
        if (exp_b.size() == 0) flag("b_we_extra");
        else check("b_wr", 64'({wr_addr, wr_data}), 64'(exp_b.pop_front()));
      end
      if (mm_start) begin
        n_start++;
        rd_idx = 0;
        check("mm_start_lat", 64'(bwe_q), 64'd1);
        check("mm_dims", 64'({mm_a_h, mm_a_w, mm_b_w}), 64'(exp_dims));
      end
      if (res_rd) begin
        check("res_rd_lat", 64'(mm_q | txd_q), 64'd1);
        check("res_addr", 64'(res_addr), 64'(rd_idx));
        rd_idx++;
      end
      if (tx_send) begin
        tx_log.push_back(tx_data);
        if (exp_tx.size() == 0) flag("tx_extra");
        else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
    end
  end

  // UART TX responder: one byte in flight, tx_done after tx_delay cycles.
  initial begin
    logic [7:0] held;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      while (tx_send) begin
        held = tx_data;
        for (int i = 0; i < tx_delay; i++) begin
          @(negedge clk);
          if (tx_send) flag("tx_overlap");
          if (tx_data !== held) flag("tx_data_unstable");
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Engine: done some cycles after start.
  initial begin
    mm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        repeat (6) @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
      end
    end
  end

  // Result RAM: data valid the cycle after res_rd, then scrambled.
  initial begin
    res_data = 32'h0;
    forever begin
      @(negedge clk);
      if (res_rd) begin
        res_data = res_mem[res_addr];
        @(negedge clk);
        @(negedge clk);
        res_data = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  // Model: expected writes, result matrix and TX byte stream for one packet.
  task automatic expect_packet(input int ah, input int aw, input int bw);
    int          s;
    logic [31:0] w;
    for (int i = 0; i < ah * aw; i++) exp_a.push_back({8'(i), f32(A_v[i])});
    for (int i = 0; i < aw * bw; i++) exp_b.push_back({8'(i), f32(B_v[i])});
    for (int r = 0; r < ah; r++)
      for (int c = 0; c < bw; c++) begin
        s = 0;
        for (int k = 0; k < aw; k++) s += A_v[r * aw + k] * B_v[k * bw + c];
        w = f32(s);
        res_mem[r * bw + c] = w;
        exp_tx.push_back(w[31:24]);
        exp_tx.push_back(w[23:16]);
        exp_tx.push_back(w[15:8]);
        exp_tx.push_back(w[7:0]);
      end
    exp_dims = {8'(ah), 8'(aw), 8'(bw)};
    exp_start++;
  endtask

  // limit < 0 sends every operand byte, else stops after limit operand bytes.
  task automatic send_packet(input int ah, input int aw, input int bh, input int bw, input int limit);
    logic [31:0] f;
    int          n;
    n = 0;
    send_byte(OP_MATRIX_MULT);
    send_byte(8'(ah));
    send_byte(8'(aw));
    send_byte(8'(bh));
    send_byte(8'(bw));
    for (int i = 0; i < ah * aw + bh * bw; i++) begin
      f = (i < ah * aw) ? f32(A_v[i]) : f32(B_v[i - ah * aw]);
      for (int b = 0; b < 4; b++) begin
        if (limit >= 0 && n >= limit) return;
        send_byte(f[31:24]);
        f = f << 8;
        n++;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 20000) begin
      @(negedge clk);
      i++;
    end
    if (busy) flag({name, "_timeout"});
  endtask

  task automatic finish_packet(input string name);
    wait_idle(name);
    check({name, "_a_left"}, 64'(exp_a.size()), 64'd0);
    check({name, "_b_left"}, 64'(exp_b.size()), 64'd0);
    check({name, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
    check({name, "_starts"}, 64'(n_start), 64'(exp_start));
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, 64'({tx_send, tx_data, a_we, b_we, wr_addr, mm_start, res_rd, res_addr, busy, err}), 64'd0);
    check({name, "_wdata"}, 64'(wr_data), 64'd0);
    check({name, "_dims"}, 64'({mm_a_h, mm_a_w, mm_b_w}), 64'd0);
  endtask

  task automatic set_ab(input int mode);
    for (int i = 0; i < 256; i++) begin
      A_v[i] = i + 1;
      B_v[i] = (mode == 0) ? i + 1 : (((i / 4) == (i % 4)) ? 2 : 0);
    end
  endtask

  initial begin
    int i;
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 4x4 happy path
    set_ab(0);
    tx_log.delete();
    wr_log.delete();
    expect_packet(4, 4, 4);
    send_packet(4, 4, 4, 4, -1);
    finish_packet("sq4");
    check("sq4_first_wdata", 64'(wr_log[0]), 64'h3F80_0000);
    check("sq4_first_res", 64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3]}), 64'h42B4_0000);
    check("sq4_tx_count", 64'(tx_log.size()), 64'd64);
    check("sq4_err", 64'(err), 64'd0);

    // Non-square 2x3 * 3x1
    tx_log.delete();
    expect_packet(2, 3, 1);
    send_packet(2, 3, 3, 1, -1);
    finish_packet("ns");
    check("ns_res0", 64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3]}), 64'h4160_0000);
    check("ns_res1", 64'({tx_log[4], tx_log[5], tx_log[6], tx_log[7]}), 64'h4200_0000);
    check("ns_tx_count", 64'(tx_log.size()), 64'd8);

    // Bad opcode
    tx_log.delete();
    exp_tx.push_back(ERR_BYTE);
    send_byte(8'h12);
    finish_packet("badop");
    check("badop_err", 64'(err), 64'd1);
    check("badop_tx_count", 64'(tx_log.size()), 64'd1);

    // Dimension mismatch, then a valid packet clears err
    exp_tx.push_back(ERR_BYTE);
    send_byte(OP_MATRIX_MULT);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h02);
    finish_packet("mism");
    check("mism_err", 64'(err), 64'd1);
    expect_packet(2, 3, 1);
    send_packet(2, 3, 3, 1, -1);
    finish_packet("recov");
    check("recov_err", 64'(err), 64'd0);

    // Reset after 6 bytes of A
    expect_packet(4, 4, 4);
    send_packet(4, 4, 4, 4, 6);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_a.delete();
    exp_b.delete();
    exp_tx.delete();
    exp_start--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_ab(1);
    tx_log.delete();
    expect_packet(4, 4, 4);
    send_packet(4, 4, 4, 4, -1);
    finish_packet("postrst");
    check("postrst_res0", 64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3]}), 64'h4000_0000);

    // Backpressure with stray and coincident rx bytes
    set_ab(0);
    tx_delay = 50;
    tx_log.delete();
    expect_packet(2, 3, 1);
    send_packet(2, 3, 3, 1, -1);
    i = 0;
    while (!tx_send && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (!tx_send) flag("bp_first_tx_timeout");
    repeat (10) @(negedge clk);
    rx_data = OP_MATRIX_MULT;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (39) @(negedge clk);
    rx_data = OP_MATRIX_MULT;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    finish_packet("bp");
    check("bp_tx_count", 64'(tx_log.size()), 64'd8);
    check("bp_res1", 64'({tx_log[4], tx_log[5], tx_log[6], tx_log[7]}), 64'h4200_0000);
    tx_delay = 2;

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
